// File: rtl/sprite_loader.sv
// Sprite block sequencer: bulk bitmap copy from source memory, CPU byte writes, shadowed x/y/scale.
// Latency: copy write 1 cycle after its read, done at n+2; CPU write 1 cycle. CPU writes dropped while busy.
module sprite_loader #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] SCALE_RESET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [31:0] length,
    output logic        busy,
    output logic        done,
    output logic        clipped,
    output logic [31:0] src_addr,
    output logic        src_oe,
    input  logic [7:0]  src_din,
    input  logic [31:0] cpu_address,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    output logic        cpu_stall,
    output logic [31:0] bitmap_address,
    output logic [7:0]  bitmap_din,
    output logic        bitmap_we,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] scale_in,
    input  logic        param_we,
    input  logic        vblank,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic [31:0] scale
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_COPY  = 2'd1;
    localparam logic [1:0]  S_FLUSH = 2'd2;
    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_BITS;

    logic [1:0]           state;
    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] last_idx;
    logic [ADDR_BITS-1:0] last_idx_nxt;
    logic                 clip_nxt;
    logic                 copy_wr;
    logic [7:0]           cpu_din_q;
    logic                 vblank_q;
    logic [31:0]          x_sh;
    logic [31:0]          y_sh;
    logic [31:0]          scale_sh;
    logic                 unused_addr_hi;

    assign clip_nxt       = (length > MAX_LEN);
    // An exact full-size length wraps to all ones, same as the clipped case.
    assign last_idx_nxt   = clip_nxt ? '1 : (length[ADDR_BITS-1:0] - ADDR_BITS'(1));
    assign cpu_stall      = busy;
    assign unused_addr_hi = ^cpu_address[31:ADDR_BITS];

    // The source memory registers its read data, so copy data is forwarded straight
    // from src_din to keep the one-cycle read-to-write pipeline.
    assign bitmap_din = copy_wr ? src_din : cpu_din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            clipped        <= 1'b0;
            src_addr       <= '0;
            src_oe         <= 1'b0;
            idx            <= '0;
            last_idx       <= '0;
            copy_wr        <= 1'b0;
            bitmap_we      <= 1'b0;
            bitmap_address <= '0;
            cpu_din_q      <= '0;
            vblank_q       <= 1'b0;
            x_sh           <= '0;
            y_sh           <= '0;
            scale_sh       <= SCALE_RESET;
            x              <= '0;
            y              <= '0;
            scale          <= SCALE_RESET;
        end else begin
            done      <= 1'b0;
            bitmap_we <= 1'b0;
            copy_wr   <= 1'b0;
            vblank_q  <= vblank;

            if (param_we) begin
                x_sh     <= x_in;
                y_sh     <= y_in;
                scale_sh <= scale_in;
            end
            if (vblank && !vblank_q) begin
                x     <= x_sh;
                y     <= y_sh;
                scale <= scale_sh;
            end

            case (state)
                S_IDLE: begin
                    if (cpu_we) begin
                        bitmap_we      <= 1'b1;
                        bitmap_address <= {{(32-ADDR_BITS){1'b0}}, cpu_address[ADDR_BITS-1:0]};
                        cpu_din_q      <= cpu_din;
                    end
                    if (start) begin
                        clipped <= clip_nxt;
                        if (length == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= S_COPY;
                            busy     <= 1'b1;
                            src_oe   <= 1'b1;
                            src_addr <= src_base;
                            idx      <= '0;
                            last_idx <= last_idx_nxt;
                        end
                    end
                end
                S_COPY: begin
                    bitmap_we      <= 1'b1;
                    copy_wr        <= 1'b1;
                    bitmap_address <= {{(32-ADDR_BITS){1'b0}}, idx};
                    if (idx == last_idx) begin
                        state  <= S_FLUSH;
                        src_oe <= 1'b0;
                    end else begin
                        idx      <= idx + ADDR_BITS'(1);
                        src_addr <= src_addr + 32'd1;
                    end
                end
                S_FLUSH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    src_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: copy timing, clipping, CPU arbitration, shadow commit, reset abort.
module tb_sprite_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] length = '0;
    logic        busy, done, clipped, src_oe, cpu_stall, bitmap_we;
    logic [31:0] src_addr, bitmap_address, x, y, scale;
    logic [7:0]  src_din = '0;
    logic [7:0]  bitmap_din;
    logic [31:0] cpu_address = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_we = 1'b0;
    logic [31:0] x_in = '0, y_in = '0, scale_in = '0;
    logic        param_we = 1'b0;
    logic        vblank = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sprite_loader #(.ADDR_BITS(12), .SCALE_RESET(32'd8)) dut (
        .clk(clk), .reset(reset_n), .start(start), .src_base(src_base), .length(length),
        .busy(busy), .done(done), .clipped(clipped), .src_addr(src_addr), .src_oe(src_oe),
        .src_din(src_din), .cpu_address(cpu_address), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .cpu_stall(cpu_stall), .bitmap_address(bitmap_address), .bitmap_din(bitmap_din),
        .bitmap_we(bitmap_we), .x_in(x_in), .y_in(y_in), .scale_in(scale_in),
        .param_we(param_we), .vblank(vblank), .x(x), .y(y), .scale(scale)
    );

    always #5 clk = ~clk;

    // Registered source memory: byte = 0xA0 + low address byte, valid the cycle after src_oe.
    always @(posedge clk) begin
        if (src_oe) src_din <= 8'hA0 + src_addr[7:0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (src_oe !== 1'b0) begin n_fail++; $display("FAIL reset_src_oe got %b exp 0", src_oe); end
        n_checks++; if (bitmap_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bitmap_we); end
        n_checks++; if (clipped !== 1'b0) begin n_fail++; $display("FAIL reset_clipped got %b exp 0", clipped); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
        n_checks++; if (x !== 32'd0 || y !== 32'd0) begin n_fail++; $display("FAIL reset_xy got %0d/%0d exp 0/0", x, y); end
        n_checks++; if (scale !== 32'd8) begin n_fail++; $display("FAIL reset_scale got %0d exp 8", scale); end
    endtask

    task automatic test_copy_basic();
        step();
        src_base = 32'h100; length = 32'd4; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            n_checks++;
            if (busy !== 1'((c >= 1) && (c <= 5))) begin n_fail++; $display("FAIL copy_busy cyc %0d got %b", c, busy); end
            n_checks++;
            if (src_oe !== 1'(c <= 4)) begin n_fail++; $display("FAIL copy_src_oe cyc %0d got %b", c, src_oe); end
            if (c <= 4) begin
                n_checks++;
                if (src_addr !== 32'h100 + 32'(c - 1)) begin n_fail++; $display("FAIL copy_src_addr cyc %0d got %h exp %h", c, src_addr, 32'h100 + 32'(c - 1)); end
            end
            n_checks++;
            if (bitmap_we !== 1'((c >= 2) && (c <= 5))) begin n_fail++; $display("FAIL copy_we cyc %0d got %b", c, bitmap_we); end
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (bitmap_address !== 32'(c - 2)) begin n_fail++; $display("FAIL copy_addr cyc %0d got %h exp %h", c, bitmap_address, c - 2); end
                n_checks++;
                if (bitmap_din !== 8'(8'hA0 + c - 2)) begin n_fail++; $display("FAIL copy_din cyc %0d got %h exp %h", c, bitmap_din, 8'(8'hA0 + c - 2)); end
            end
            n_checks++;
            if (done !== 1'(c == 6)) begin n_fail++; $display("FAIL copy_done cyc %0d got %b", c, done); end
        end
    endtask

    task automatic test_clip();
        int writes = 0;
        int done_cyc = -1;
        int c = 1;
        logic [31:0] last_addr = '0;
        logic [7:0]  last_din = '0;
        logic        clip_at_done = 1'b0;
        step();
        src_base = 32'h0; length = 32'd5000; start = 1'b1;
        step();
        start = 1'b0;
        while (c <= 4200 && done_cyc < 0) begin
            if (bitmap_we) begin writes++; last_addr = bitmap_address; last_din = bitmap_din; end
            if (done) begin done_cyc = c; clip_at_done = clipped; end
            else begin step(); c++; end
        end
        n_checks++; if (done_cyc != 4098) begin n_fail++; $display("FAIL clip_done_cycle got %0d exp 4098", done_cyc); end
        n_checks++; if (writes != 4096) begin n_fail++; $display("FAIL clip_writes got %0d exp 4096", writes); end
        n_checks++; if (last_addr !== 32'hFFF) begin n_fail++; $display("FAIL clip_last_addr got %h exp fff", last_addr); end
        n_checks++; if (last_din !== 8'h9F) begin n_fail++; $display("FAIL clip_last_din got %h exp 9f", last_din); end
        n_checks++; if (clip_at_done !== 1'b1) begin n_fail++; $display("FAIL clip_flag got %b exp 1", clip_at_done); end
    endtask

    task automatic test_zero_length();
        step();
        length = 32'd0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", done); end
        n_checks++; if (busy !== 1'b0 || src_oe !== 1'b0 || bitmap_we !== 1'b0) begin n_fail++; $display("FAIL zero_idle got busy %b oe %b we %b exp 0 0 0", busy, src_oe, bitmap_we); end
        n_checks++; if (clipped !== 1'b0) begin n_fail++; $display("FAIL zero_clipped got %b exp 0", clipped); end
        step();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || src_oe !== 1'b0 || bitmap_we !== 1'b0) begin n_fail++; $display("FAIL zero_after got done %b busy %b oe %b we %b exp 0", done, busy, src_oe, bitmap_we); end
    endtask

    task automatic test_cpu_write();
        int bad = 0;
        int c = 0;
        step();
        src_base = 32'h100; length = 32'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cpu_we = 1'b1; cpu_address = 32'd7; cpu_din = 8'h55;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL cpu_stall_busy got %b exp 1", cpu_stall); end
        while (!done && c < 30) begin
            step();
            cpu_we = 1'b0;
            if (bitmap_we && bitmap_din === 8'h55) bad++;
            c++;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL cpu_copy_done got %b exp 1", done); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL cpu_dropped got %0d writes exp 0", bad); end
        step();
        cpu_we = 1'b1; cpu_address = 32'h1007; cpu_din = 8'h55;
        step();
        cpu_we = 1'b0;
        n_checks++; if (bitmap_we !== 1'b1) begin n_fail++; $display("FAIL cpu_idle_we got %b exp 1", bitmap_we); end
        n_checks++; if (bitmap_address !== 32'd7) begin n_fail++; $display("FAIL cpu_idle_addr got %h exp 7", bitmap_address); end
        n_checks++; if (bitmap_din !== 8'h55) begin n_fail++; $display("FAIL cpu_idle_din got %h exp 55", bitmap_din); end
        step();
        n_checks++; if (bitmap_we !== 1'b0) begin n_fail++; $display("FAIL cpu_idle_single got %b exp 0", bitmap_we); end
    endtask

    task automatic test_back_to_back();
        step();
        cpu_we = 1'b1; cpu_address = 32'd3; cpu_din = 8'h3C;
        src_base = 32'h100; length = 32'd2; start = 1'b1;
        step();
        cpu_we = 1'b0; start = 1'b0;
        n_checks++; if (bitmap_we !== 1'b1 || bitmap_address !== 32'd3 || bitmap_din !== 8'h3C) begin n_fail++; $display("FAIL b2b_cpu got we %b addr %h din %h exp 1 3 3c", bitmap_we, bitmap_address, bitmap_din); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
        length = 32'd100; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (bitmap_we !== 1'b1 || bitmap_address !== 32'd0 || bitmap_din !== 8'hA0) begin n_fail++; $display("FAIL b2b_w0 got we %b addr %h din %h exp 1 0 a0", bitmap_we, bitmap_address, bitmap_din); end
        step();
        n_checks++; if (bitmap_we !== 1'b1 || bitmap_address !== 32'd1 || bitmap_din !== 8'hA1) begin n_fail++; $display("FAIL b2b_w1 got we %b addr %h din %h exp 1 1 a1", bitmap_we, bitmap_address, bitmap_din); end
        step();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done got done %b busy %b exp 1 0", done, busy); end
        step();
        n_checks++; if (busy !== 1'b0 || src_oe !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored got busy %b oe %b exp 0 0", busy, src_oe); end
    endtask

    task automatic test_shadow();
        step();
        x_in = 32'd100; y_in = 32'd200; scale_in = 32'd16; param_we = 1'b1;
        step();
        param_we = 1'b0;
        n_checks++; if (x !== 32'd0 || scale !== 32'd8) begin n_fail++; $display("FAIL shadow_early got x %0d scale %0d exp 0 8", x, scale); end
        vblank = 1'b1;
        step();
        n_checks++; if (x !== 32'd100 || y !== 32'd200 || scale !== 32'd16) begin n_fail++; $display("FAIL shadow_commit got %0d/%0d/%0d exp 100/200/16", x, y, scale); end
        vblank = 1'b0;
        step();
        step();
        x_in = 32'd300; param_we = 1'b1; vblank = 1'b1;
        step();
        param_we = 1'b0;
        n_checks++; if (x !== 32'd100) begin n_fail++; $display("FAIL shadow_edge_old got %0d exp 100", x); end
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        n_checks++; if (x !== 32'd300) begin n_fail++; $display("FAIL shadow_next_edge got %0d exp 300", x); end
        vblank = 1'b0;
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        step();
        src_base = 32'h100; length = 32'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bitmap_we !== 1'b0 || src_oe !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy %b we %b oe %b exp 0 0 0", busy, bitmap_we, src_oe); end
        n_checks++; if (scale !== 32'd8 || x !== 32'd0) begin n_fail++; $display("FAIL abort_params got scale %0d x %0d exp 8 0", scale, x); end
        step();
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bitmap_we || src_oe || done || busy) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles exp 0", bad); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        test_copy_basic();
        test_clip();
        test_zero_length();
        test_cpu_write();
        test_back_to_back();
        test_shadow();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
